// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port between NumReq requesters.
// Optional burst stall timeout enabled by defining FIFO_ARB_TIMEOUT_EN.
module fifo_wr_arbiter #(
  parameter int NumReq        = 4,
  parameter int DataWidth     = 8,
  parameter int BurstLen      = 4
`ifdef FIFO_ARB_TIMEOUT_EN
  , parameter int TimeoutCycles = 16
`endif
) (
  input  logic                          clk_i,
  input  logic                          nrst_i,
  input  logic [NumReq-1:0]             req_i,
  input  logic [NumReq*DataWidth-1:0]   data_i,
  input  logic                          full_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic                          wr_inc_o,
  output logic [DataWidth-1:0]          wr_data_o,
  output logic                          busy_o
`ifdef FIFO_ARB_TIMEOUT_EN
  , output logic                        timeout_o
`endif
);

  localparam int OwnW = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = $clog2(BurstLen) + 1;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  state_e              state_q, state_d;
  logic [OwnW-1:0]     owner_q, owner_d;
  logic [OwnW-1:0]     last_owner_q, last_owner_d;
  logic [CntW-1:0]     burst_cnt_q, burst_cnt_d;
  logic [NumReq-1:0]   gnt_q, gnt_d;

  logic [OwnW-1:0]     pick;
  logic [OwnW-1:0]     idx;
  logic                pick_vld;
  logic                owner_req;
  logic                xfer;
  logic                burst_done;
  logic                end_burst;

`ifdef FIFO_ARB_TIMEOUT_EN
  localparam int StallW = $clog2(TimeoutCycles) + 1;
  logic [StallW-1:0]   stall_cnt_q, stall_cnt_d;
  logic                timeout_q, timeout_d;
  logic                stall;
  logic                timeout_hit;
`endif

  // Search starts one past the previous owner so a just-released owner yields.
  always_comb begin : rr_pick
    pick     = last_owner_q;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = 1; i <= NumReq; i++) begin
      idx = OwnW'((int'(last_owner_q) + i) % NumReq);
      if (!pick_vld && req_i[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign owner_req  = req_i[owner_q];
  assign xfer       = (state_q == BURST) && owner_req && !full_i;
  assign burst_done = xfer && (burst_cnt_q == CntW'(BurstLen - 1));

`ifdef FIFO_ARB_TIMEOUT_EN
  assign stall       = (state_q == BURST) && owner_req && full_i;
  assign timeout_hit = stall && (stall_cnt_q == StallW'(TimeoutCycles - 1));
  assign end_burst   = !owner_req || burst_done || timeout_hit;
`else
  assign end_burst   = !owner_req || burst_done;
`endif

  always_comb begin : fsm_next
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    gnt_d        = gnt_q;
`ifdef FIFO_ARB_TIMEOUT_EN
    stall_cnt_d  = stall_cnt_q;
    timeout_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        gnt_d       = '0;
        burst_cnt_d = '0;
        if (pick_vld) begin
          state_d = BURST;
          owner_d = pick;
          gnt_d   = NumReq'(1) << pick;
`ifdef FIFO_ARB_TIMEOUT_EN
          stall_cnt_d = '0;
`endif
        end
      end
      BURST: begin
        if (end_burst) begin
          state_d      = IDLE;
          gnt_d        = '0;
          last_owner_d = owner_q;
          burst_cnt_d  = '0;
`ifdef FIFO_ARB_TIMEOUT_EN
          stall_cnt_d  = '0;
          timeout_d    = timeout_hit;
`endif
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + CntW'(1);
`ifdef FIFO_ARB_TIMEOUT_EN
          stall_cnt_d = '0;
        end else if (stall) begin
          stall_cnt_d = stall_cnt_q + StallW'(1);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= OwnW'(NumReq - 1);
      burst_cnt_q  <= '0;
      gnt_q        <= '0;
`ifdef FIFO_ARB_TIMEOUT_EN
      stall_cnt_q  <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      gnt_q        <= gnt_d;
`ifdef FIFO_ARB_TIMEOUT_EN
      stall_cnt_q  <= stall_cnt_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  // Data path is combinational from the registered owner and gated by state.
  assign gnt_o     = gnt_q;
  assign busy_o    = (state_q == BURST);
  assign wr_inc_o  = xfer;
  assign wr_data_o = (state_q == BURST) ? data_i[int'(owner_q)*DataWidth +: DataWidth]
                                        : '0;
`ifdef FIFO_ARB_TIMEOUT_EN
  assign timeout_o = timeout_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester models feed words, a monitor scores writes.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 8;

  logic            clk;
  logic            nrst_i;
  logic [NR-1:0]   req_i;
  logic [NR*DW-1:0] data_i;
  logic            full_i;
  logic [NR-1:0]   gnt_o;
  logic            wr_inc_o;
  logic [DW-1:0]   wr_data_o;
  logic            busy_o;

  fifo_wr_arbiter #(.NumReq(NR), .DataWidth(DW), .BurstLen(4)) dut (
    .clk_i     (clk),
    .nrst_i    (nrst_i),
    .req_i     (req_i),
    .data_i    (data_i),
    .full_i    (full_i),
    .gnt_o     (gnt_o),
    .wr_inc_o  (wr_inc_o),
    .wr_data_o (wr_data_o),
    .busy_o    (busy_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // scoreboard entry: {grant, data}
  logic [NR+DW-1:0] exp_q[$];

  // requester models: each holds req while it still has words to send
  logic [DW-1:0] src_mem [NR][8];
  int            src_len [NR];
  int            src_ptr [NR];
  logic          acc_v;
  logic [NR-1:0] acc_g;

  task automatic drive_inputs();
    for (int k = 0; k < NR; k++) begin
      req_i[k] = (src_ptr[k] < src_len[k]);
      data_i[k*DW +: DW] = req_i[k] ? src_mem[k][src_ptr[k]] : '0;
    end
  endtask

  task automatic load(input int k, input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) src_mem[k][i] = base + DW'(i);
    src_len[k] = n;
    src_ptr[k] = 0;
  endtask

  task automatic clear_srcs();
    for (int k = 0; k < NR; k++) begin
      src_len[k] = 0;
      src_ptr[k] = 0;
    end
  endtask

  task automatic expect_words(input logic [NR-1:0] g, input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({g, base + DW'(i)});
  endtask

  // driver: a word observed as written at negedge is retired after the next posedge
  always begin
    @(negedge clk);
    acc_v = wr_inc_o;
    acc_g = gnt_o;
    @(posedge clk);
    #1;
    if (acc_v) begin
      for (int k = 0; k < NR; k++) if (acc_g[k]) src_ptr[k]++;
    end
    drive_inputs();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // table entries read left to right in the literal
  task automatic chk_gnt_seq(input string name, input logic [63:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk($sformatf("%s_gnt%0d", name, i), 32'(gnt_o), 32'(seq[(n-1-i)*4 +: 4]));
    end
  endtask

  task automatic do_reset();
    nrst_i = 1'b0;
    full_i = 1'b0;
    clear_srcs();
    repeat (2) @(negedge clk);
    nrst_i = 1'b1;
    @(negedge clk);
  endtask

  // monitor: every write is matched against the expected queue
  always @(negedge clk) begin
    if (nrst_i && wr_inc_o) begin
      vectors++;
      if (full_i) begin
        miscompares++;
        $display("FAIL sb_write_while_full: wr_inc_o=1 with full_i=1");
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected: gnt=%0h data=%0h with nothing expected", gnt_o, wr_data_o);
      end else begin
        logic [NR+DW-1:0] e;
        e = exp_q.pop_front();
        if ({gnt_o, wr_data_o} !== e) begin
          miscompares++;
          $display("FAIL sb_write: got gnt=%0h data=%0h, expected gnt=%0h data=%0h",
                   gnt_o, wr_data_o, e[NR+DW-1:DW], e[DW-1:0]);
        end
      end
    end
  end

  initial begin
    int wcnt;
    logic [3:0] e;
    nrst_i = 1'b0;
    full_i = 1'b0;
    req_i  = '0;
    data_i = '0;
    clear_srcs();

    // T1: single requester, burst split by bubble
    do_reset();
    chk("rst_gnt", 32'(gnt_o), 0);
    chk("rst_wr_inc", 32'(wr_inc_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_wr_data", 32'(wr_data_o), 0);
    load(0, 6, 8'hA0);
    expect_words(4'b0001, 8'hA0, 6);
    chk_gnt_seq("t1", 64'h0111101110, 10);

    // T2: all four requesting, round-robin 0,1,2,3,0
    do_reset();
    load(0, 8, 8'hB0);
    load(1, 4, 8'hC0);
    load(2, 4, 8'hD0);
    load(3, 4, 8'hE0);
    expect_words(4'b0001, 8'hB0, 4);
    expect_words(4'b0010, 8'hC0, 4);
    expect_words(4'b0100, 8'hD0, 4);
    expect_words(4'b1000, 8'hE0, 4);
    expect_words(4'b0001, 8'hB4, 4);
    wcnt = 0;
    for (int n = 1; n <= 26; n++) begin
      @(negedge clk);
      if (n == 1) e = 4'b0000;
      else e = (((n - 2) % 5) == 4) ? 4'b0000 : 4'(1 << (((n - 2) / 5) % 4));
      chk($sformatf("t2_gnt%0d", n), 32'(gnt_o), 32'(e));
      if (n >= 2 && n <= 25 && wr_inc_o) wcnt++;
    end
    chk("t2_writes_in_24", 32'(wcnt), 20);

    // T3: full stalls owner 2 after two writes
    do_reset();
    load(2, 4, 8'h30);
    expect_words(4'b0100, 8'h30, 4);
    chk_gnt_seq("t3a", 64'h044, 3);
    @(posedge clk);
    #2 full_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t3_full_wr_inc%0d", i), 32'(wr_inc_o), 0);
      chk($sformatf("t3_full_gnt%0d", i), 32'(gnt_o), 32'h4);
    end
    @(posedge clk);
    #2 full_i = 1'b0;
    wcnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (wr_inc_o) wcnt++;
      chk($sformatf("t3b_gnt%0d", i), 32'(gnt_o), (i < 2) ? 32'h4 : 32'h0);
    end
    chk("t3_writes_after_full", 32'(wcnt), 2);

    // T4: owner 1 releases after one word, requester 3 takes over
    do_reset();
    load(1, 1, 8'h41);
    load(3, 2, 8'h60);
    expect_words(4'b0010, 8'h41, 1);
    expect_words(4'b1000, 8'h60, 2);
    chk_gnt_seq("t4", 64'h02208880, 8);

    // T5: asynchronous reset mid-burst, then restart at requester 2
    do_reset();
    load(0, 4, 8'h50);
    expect_words(4'b0001, 8'h50, 1);
    chk_gnt_seq("t5a", 64'h01, 2);
    @(posedge clk);
    #3 nrst_i = 1'b0;
    #1;
    chk("t5_rst_gnt", 32'(gnt_o), 0);
    chk("t5_rst_wr_inc", 32'(wr_inc_o), 0);
    chk("t5_rst_busy", 32'(busy_o), 0);
    chk("t5_rst_wr_data", 32'(wr_data_o), 0);
    clear_srcs();
    repeat (2) @(negedge clk);
    nrst_i = 1'b1;
    @(negedge clk);
    load(2, 4, 8'h70);
    expect_words(4'b0100, 8'h70, 4);
    chk_gnt_seq("t5b", 64'h044440, 6);

    repeat (4) @(negedge clk);
    chk("sb_drain", 32'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
